// File: rtl/systolic_mm_engine.sv
// systolic_mm_engine
//   Self-sequencing signed matrix multiply C[ROWS x COLS] = A[ROWS x K] * B[K x COLS]
//   on an output-stationary ROWS x COLS MAC grid with internal triangular input skew.
//   Optional feature macro: SYSTOLIC_SAT_EN (saturating accumulate + sticky sat_flag);
//   when undefined, accumulation wraps and sat_flag is tied low.
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, k_len, busy, done   launch (honoured in IDLE), inner dimension, status
//   in_valid/in_ready          A column (a_col) + B row (b_row) beat stream
//   out_valid/out_ready        one C row per beat on out_row, with out_row_idx/out_last
//   sat_flag                   sticky saturation indicator for the current operation
module systolic_mm_engine #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int MAX_K      = 256,
  localparam int KW        = $clog2(MAX_K + 1),
  localparam int RIW       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [KW-1:0]              k_len,
  output logic                       busy,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] a_col,
  input  logic [COLS*DATA_WIDTH-1:0] b_row,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [COLS*ACC_WIDTH-1:0]  out_row,
  output logic [RIW-1:0]             out_row_idx,
  output logic                       out_last,
  output logic                       done,
  output logic                       sat_flag
);
  localparam int FLUSH_N = ROWS + COLS - 2;
  localparam int CW      = $clog2(MAX_K + ROWS + COLS + 1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
  // A 1x1 grid has nothing to flush
  localparam logic [1:0] S_POST_LOAD = (FLUSH_N == 0) ? S_DRAIN : S_FLUSH;

  logic [1:0]     state_q, state_d;
  logic [KW-1:0]  k_q, k_d, k_clamped;
  logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [RIW-1:0] row_q, row_d;
  logic           done_q, done_d;
  logic           clear, accept, advance, feed;

  logic signed [DATA_WIDTH-1:0] a_skew [ROWS];
  logic signed [DATA_WIDTH-1:0] b_skew [COLS];
  logic signed [DATA_WIDTH-1:0] a_left [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0] b_up   [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0] a_pe_q [ROWS][COLS], a_pe_d [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0] b_pe_q [ROWS][COLS], b_pe_d [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0]  acc_q  [ROWS][COLS], acc_d  [ROWS][COLS];

  assign clear     = (state_q == S_IDLE) && start;
  assign accept    = in_valid && (state_q == S_LOAD);
  // An in_valid gap freezes grid and skew lines alike, so gaps never change results
  assign advance   = accept || (state_q == S_FLUSH);
  // Outside LOAD the skew inputs see zeros (flush)
  assign feed      = (state_q == S_LOAD);
  assign k_clamped = (k_len > KW'(MAX_K)) ? KW'(MAX_K) : k_len;
  assign cnt_inc   = cnt_q + 1'b1;

  // Control FSM
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        k_d     = k_clamped;
        cnt_d   = '0;
        row_d   = '0;
        state_d = (k_clamped == '0) ? S_POST_LOAD : S_LOAD;
      end
      S_LOAD: if (accept) begin
        if (cnt_inc == CW'(k_q)) begin
          cnt_d   = '0;
          state_d = S_POST_LOAD;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_FLUSH: begin
        if (cnt_inc == CW'(FLUSH_N)) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DRAIN: if (out_ready) begin
        if (row_q == RIW'(ROWS - 1)) begin
          row_d   = '0;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  // Input skew: A row r delayed r advances
  for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
    logic signed [DATA_WIDTH-1:0] a_src;
    assign a_src = feed ? a_col[r*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (r == 0) begin : g_tap
      assign a_skew[r] = a_src;
    end else begin : g_line
      logic signed [DATA_WIDTH-1:0] line_q [r];
      logic signed [DATA_WIDTH-1:0] line_d [r];
      always_comb begin
        for (int i = 0; i < r; i++) line_d[i] = line_q[i];
        if (clear) begin
          for (int i = 0; i < r; i++) line_d[i] = '0;
        end else if (advance) begin
          line_d[0] = a_src;
          for (int i = 1; i < r; i++) line_d[i] = line_q[i-1];
        end
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < r; i++) line_q[i] <= '0;
        end else begin
          for (int i = 0; i < r; i++) line_q[i] <= line_d[i];
        end
      end
      assign a_skew[r] = line_q[r-1];
    end
  end

  // Input skew: B column c delayed c advances
  for (genvar c = 0; c < COLS; c++) begin : g_b_skew
    logic signed [DATA_WIDTH-1:0] b_src;
    assign b_src = feed ? b_row[c*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (c == 0) begin : g_tap
      assign b_skew[c] = b_src;
    end else begin : g_line
      logic signed [DATA_WIDTH-1:0] line_q [c];
      logic signed [DATA_WIDTH-1:0] line_d [c];
      always_comb begin
        for (int i = 0; i < c; i++) line_d[i] = line_q[i];
        if (clear) begin
          for (int i = 0; i < c; i++) line_d[i] = '0;
        end else if (advance) begin
          line_d[0] = b_src;
          for (int i = 1; i < c; i++) line_d[i] = line_q[i-1];
        end
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < c; i++) line_q[i] <= '0;
        end else begin
          for (int i = 0; i < c; i++) line_q[i] <= line_d[i];
        end
      end
      assign b_skew[c] = line_q[c-1];
    end
  end

  // PE operand routing: a enters from the left edge, b from the top edge
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      if (c == 0) begin : g_a_edge
        assign a_left[r][c] = a_skew[r];
      end else begin : g_a_int
        assign a_left[r][c] = a_pe_q[r][c-1];
      end
      if (r == 0) begin : g_b_edge
        assign b_up[r][c] = b_skew[c];
      end else begin : g_b_int
        assign b_up[r][c] = b_pe_q[r-1][c];
      end
    end
  end

`ifdef SYSTOLIC_SAT_EN
  logic sat_hit;
  logic sat_q, sat_d;

  // Returns {clipped, sum} with the sum clamped to the signed ACC_WIDTH range
  function automatic logic [ACC_WIDTH:0] sat_add(input logic signed [ACC_WIDTH-1:0] x,
                                                 input logic signed [ACC_WIDTH-1:0] y);
    logic signed [ACC_WIDTH:0] s;
    s = (ACC_WIDTH+1)'(x) + (ACC_WIDTH+1)'(y);
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
      if (s[ACC_WIDTH]) return {1'b1, 1'b1, {(ACC_WIDTH-1){1'b0}}};
      else              return {1'b1, 1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
    return {1'b0, s[ACC_WIDTH-1:0]};
  endfunction
`endif

  // MAC grid
  always_comb begin
    logic signed [ACC_WIDTH-1:0] prod;
`ifdef SYSTOLIC_SAT_EN
    logic sat_bit;
    sat_bit = 1'b0;
    sat_hit = 1'b0;
`endif
    prod   = '0;
    a_pe_d = a_pe_q;
    b_pe_d = b_pe_q;
    acc_d  = acc_q;
    if (clear) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          a_pe_d[r][c] = '0;
          b_pe_d[r][c] = '0;
          acc_d[r][c]  = '0;
        end
      end
    end else if (advance) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          a_pe_d[r][c] = a_left[r][c];
          b_pe_d[r][c] = b_up[r][c];
          prod = ACC_WIDTH'(a_left[r][c]) * ACC_WIDTH'(b_up[r][c]);
`ifdef SYSTOLIC_SAT_EN
          {sat_bit, acc_d[r][c]} = sat_add(acc_q[r][c], prod);
          sat_hit = sat_hit | sat_bit;
`else
          acc_d[r][c] = acc_q[r][c] + prod;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          a_pe_q[r][c] <= '0;
          b_pe_q[r][c] <= '0;
          acc_q[r][c]  <= '0;
        end
      end
    end else begin
      a_pe_q <= a_pe_d;
      b_pe_q <= b_pe_d;
      acc_q  <= acc_d;
    end
  end

`ifdef SYSTOLIC_SAT_EN
  assign sat_d = clear ? 1'b0 : (sat_q | sat_hit);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_q <= 1'b0;
    else        sat_q <= sat_d;
  end
  assign sat_flag = sat_q;
`else
  assign sat_flag = 1'b0;
`endif

  // Result drain
  always_comb begin
    out_row = '0;
    for (int c = 0; c < COLS; c++) out_row[c*ACC_WIDTH +: ACC_WIDTH] = acc_q[row_q][c];
  end

  assign busy        = (state_q != S_IDLE);
  assign in_ready    = (state_q == S_LOAD);
  assign out_valid   = (state_q == S_DRAIN);
  assign out_row_idx = row_q;
  assign out_last    = out_valid && (row_q == RIW'(ROWS - 1));
  assign done        = done_q;
endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed bench for systolic_mm_engine (8x8 grid, 8-bit operands, 16-bit accumulators).
module tb_systolic_mm_engine;
  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int DW    = 8;
  localparam int AW    = 16;
  localparam int MAX_K = 256;
  localparam int KW    = $clog2(MAX_K + 1);
  localparam int RW    = $clog2(ROWS);
  localparam int OW    = COLS * AW;
  localparam longint MAXV = (64'sd1 <<< (AW - 1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (AW - 1));

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [KW-1:0]     k_len = '0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [ROWS*DW-1:0] a_col = '0;
  logic [COLS*DW-1:0] b_row = '0;
  logic              busy, in_ready, out_valid, out_last, done, sat_flag;
  logic [OW-1:0]     out_row;
  logic [RW-1:0]     out_row_idx;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;

  int            a_m [ROWS][MAX_K];
  int            b_m [MAX_K][COLS];
  logic [OW-1:0] exp_row [ROWS];
  logic [OW-1:0] got_row [ROWS];
  logic          exp_sat;

  systolic_mm_engine #(
    .ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .MAX_K(MAX_K)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_row_idx(out_row_idx), .out_last(out_last), .done(done), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Golden model: per-step accumulate in 64-bit, then clamp or wrap to AW bits
  task automatic build_exp(input int k);
    longint acc, s;
    logic signed [AW-1:0] w;
    exp_sat = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        acc = 0;
        for (int kk = 0; kk < k; kk++) begin
          s = acc + longint'(a_m[i][kk] * b_m[kk][j]);
`ifdef SYSTOLIC_SAT_EN
          if (s > MAXV) begin s = MAXV; exp_sat = 1'b1; end
          else if (s < MINV) begin s = MINV; exp_sat = 1'b1; end
`else
          w = s[AW-1:0];
          s = longint'(w);
`endif
          acc = s;
        end
        exp_row[i][j*AW +: AW] = acc[AW-1:0];
      end
    end
  endtask

  task automatic run_op(input string pfx, input int k, input bit gaps, input int stall_row,
                        input bit poke, input int exp_lat);
    int beat, guard, t0, seen, d0;
    logic acc_ok, stable;
    logic [OW-1:0] held;
    logic [RW-1:0] held_idx, idx;
    build_exp(k);
    d0 = done_cnt;
    @(posedge clk); #1;
    k_len = KW'(k);
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    chk({pfx, "_busy"}, OW'(busy), OW'(1));
    beat = 0;
    guard = 0;
    while (beat < k && guard < 4 * MAX_K + 8) begin
      in_valid = gaps ? guard[0] : 1'b1;
      for (int r = 0; r < ROWS; r++) a_col[r*DW +: DW] = DW'(a_m[r][beat]);
      for (int c = 0; c < COLS; c++) b_row[c*DW +: DW] = DW'(b_m[beat][c]);
      acc_ok = in_valid & in_ready;
      @(posedge clk); #1;
      if (acc_ok) beat++;
      guard++;
    end
    in_valid = 1'b0;
    a_col = '0;
    b_row = '0;
    chk({pfx, "_beats"}, OW'(beat), OW'(k));
    chk({pfx, "_rdy_flush"}, OW'(in_ready), OW'(0));
    guard = 0;
    while (!out_valid && guard < 64) begin
      start = (poke && guard == 2);
      @(posedge clk); #1;
      guard++;
    end
    start = 1'b0;
    chk({pfx, "_ovalid"}, OW'(out_valid), OW'(1));
    if (exp_lat > 0) chk({pfx, "_latency"}, OW'(cyc - t0), OW'(exp_lat));
    chk({pfx, "_rdy_drain"}, OW'(in_ready), OW'(0));
    seen = 0;
    guard = 0;
    while (seen < ROWS && guard < 64) begin
      if (out_valid && int'(out_row_idx) == stall_row) begin
        out_ready = 1'b0;
        held = out_row;
        held_idx = out_row_idx;
        stable = 1'b1;
        repeat (5) begin
          @(posedge clk); #1;
          if (out_row !== held || out_row_idx !== held_idx || out_valid !== 1'b1) stable = 1'b0;
        end
        chk({pfx, "_stall_hold"}, OW'(stable), OW'(1));
        stall_row = -1;
      end
      out_ready = 1'b1;
      if (out_valid) begin
        idx = out_row_idx;
        got_row[idx] = out_row;
        chk({pfx, "_idx"}, OW'(idx), OW'(seen));
        chk({pfx, "_row"}, out_row, exp_row[idx]);
        chk({pfx, "_last"}, OW'(out_last), OW'(idx == RW'(ROWS - 1)));
        seen++;
      end
      @(posedge clk); #1;
      guard++;
    end
    out_ready = 1'b0;
    chk({pfx, "_rows"}, OW'(seen), OW'(ROWS));
    chk({pfx, "_done"}, OW'(done), OW'(1));
    chk({pfx, "_idle"}, OW'({busy, in_ready, out_valid}), OW'(0));
    chk({pfx, "_sat"}, OW'(sat_flag), OW'(exp_sat));
    @(posedge clk); #1;
    chk({pfx, "_done_low"}, OW'(done), OW'(0));
    chk({pfx, "_done_once"}, OW'(done_cnt - d0), OW'(1));
  endtask

  initial begin
    #2;
    chk("rst_ctl", OW'({busy, in_ready, out_valid, out_last, done, sat_flag}), OW'(0));
    chk("rst_row", out_row, OW'(0));
    chk("rst_idx", OW'(out_row_idx), OW'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Identity A, B[k][c] = 8k+c: C = B
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < 8; k++) a_m[r][k] = (r == k) ? 1 : 0;
    for (int k = 0; k < 8; k++)
      for (int c = 0; c < COLS; c++) b_m[k][c] = 8 * k + c;
    run_op("t1", 8, 1'b0, -1, 1'b0, 23);
    chk("t1_c25", OW'(got_row[2][5*AW +: AW]), OW'(21));
    chk("t1_c70", OW'(got_row[7][0*AW +: AW]), OW'(56));

    // Mixed-sign operands, K=3, with and without input gaps
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < 3; k++) a_m[r][k] = ((r * 37 + k * 11 + 5) % 201) - 100;
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < COLS; c++) b_m[k][c] = ((k * 23 + c * 53 + 17) % 201) - 100;
    run_op("t2_gapless", 3, 1'b0, -1, 1'b0, 18);
    run_op("t2_gapped", 3, 1'b1, -1, 1'b0, 0);

    // Output back-pressure on row 2
    run_op("t3_stall", 3, 1'b0, 2, 1'b0, 0);

    // Full-length K with maximal positive operands
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < MAX_K; k++) a_m[r][k] = 127;
    for (int k = 0; k < MAX_K; k++)
      for (int c = 0; c < COLS; c++) b_m[k][c] = 127;
    run_op("t4_big", 256, 1'b0, -1, 1'b0, 271);
`ifdef SYSTOLIC_SAT_EN
    chk("t4_c53", OW'(got_row[5][3*AW +: AW]), OW'(32767));
`else
    chk("t4_c53", OW'(got_row[5][3*AW +: AW]), OW'(256));
`endif

    // K=0 with a stray start while busy
    run_op("t6_k0", 0, 1'b0, -1, 1'b1, 0);

    // Reset in the middle of LOAD (fourth beat on the bus)
    @(posedge clk); #1;
    k_len = KW'(8);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    for (int r = 0; r < ROWS; r++) a_col[r*DW +: DW] = DW'(127);
    for (int c = 0; c < COLS; c++) b_row[c*DW +: DW] = DW'(127);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_ctl", OW'({busy, in_ready, out_valid, out_last, done, sat_flag}), OW'(0));
    chk("t5_rst_row", out_row, OW'(0));
    chk("t5_rst_idx", OW'(out_row_idx), OW'(0));
    in_valid = 1'b0;
    a_col = '0;
    b_row = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < 2; k++) a_m[r][k] = r - 3 * k;
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < COLS; c++) b_m[k][c] = c + k - 4;
    run_op("t5_after_rst", 2, 1'b0, -1, 1'b0, 17);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
